// File: rtl/io_shift_reg_pkg.sv
// Shared types and helpers for the io_shift_reg block.
package io_shift_reg_pkg;

    // Direction in which the register moves its contents on each accepted shift.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,  // serial in at bit WIDTH-1, out from bit 0
        ORDER_MSB_FIRST = 1'b1   // serial in at bit 0, out from bit WIDTH-1
    } bit_order_e;

    // Width of a counter that must be able to hold the value `width`.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/io_shift_reg_if.sv
// Bundles the serial-link and IO-port signals of one io_shift_reg instance.
// The master side drives the shift clock, data and controls; the slave side
// is the shift register itself.
interface io_shift_reg_if #(
    parameter int WIDTH = 32
);
    import io_shift_reg_pkg::*;

    localparam int CW = count_width(WIDTH);

    logic             shiftClk;
    logic             serialInput;
    logic             enableShift;
    logic             load;
    logic [WIDTH-1:0] parallelInput;
    logic [WIDTH-1:0] parallelOutput;
    logic             serialOutput;
    logic             loaded;
    logic             frameDone;
    logic [CW-1:0]    bitCount;
    logic             collision;

    modport master (
        output shiftClk,
        output serialInput,
        output enableShift,
        output load,
        output parallelInput,
        input  parallelOutput,
        input  serialOutput,
        input  loaded,
        input  frameDone,
        input  bitCount,
        input  collision
    );

    modport slave (
        input  shiftClk,
        input  serialInput,
        input  enableShift,
        input  load,
        input  parallelInput,
        output parallelOutput,
        output serialOutput,
        output loaded,
        output frameDone,
        output bitCount,
        output collision
    );

endinterface

// File: rtl/io_shift_reg_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous clock-like input plus a
// rising-edge pulse, with a data bus carried through an identical chain so
// the data stays aligned with the detected edge.
module io_shift_reg_sync_edge_det
    import io_shift_reg_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              async_clk,
    input  logic [DATA_W-1:0] async_data,
    output logic [DATA_W-1:0] sync_data,
    output logic              rise
);

    logic [STAGES-1:0]             clk_sync_q, clk_sync_d;
    logic                          clk_dly_q, clk_dly_d;
    logic [STAGES-1:0][DATA_W-1:0] data_sync_q, data_sync_d;

    // Next state of both synchroniser chains and the edge-detect delay flop.
    always_comb begin
        clk_sync_d  = {clk_sync_q[STAGES-2:0], async_clk};
        clk_dly_d   = clk_sync_q[STAGES-1];
        data_sync_d = {data_sync_q[STAGES-2:0], async_data};
    end

    // Synchroniser registers; cleared on reset so no edge appears afterwards.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            clk_sync_q  <= '0;
            clk_dly_q   <= 1'b0;
            data_sync_q <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            clk_dly_q   <= clk_dly_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign rise      = clk_sync_q[STAGES-1] & ~clk_dly_q;
    assign sync_data = data_sync_q[STAGES-1];

endmodule

// File: rtl/io_shift_reg.sv
// WIDTH-bit serial/parallel shift register clocked from masterClk. The
// asynchronous shiftClk is synchronised and its rising edges shift in the
// synchronised serialInput. Adds selectable bit order, a frame bit counter
// with a frame-done pulse, an optional shadow parallel output and sticky
// load/shift collision detection.
module io_shift_reg
    import io_shift_reg_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int OUT_LATCHED = 0
) (
    input  logic          masterClk,
    input  logic          rst,
    io_shift_reg_if.slave bus
);

    localparam int         CW    = count_width(WIDTH);
    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic             shift_edge;
    logic             ser_in_sync;
    logic             accept_shift;
    logic [WIDTH-1:0] shifted;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic             done_q, done_d;
    logic             coll_q, coll_d;

    // shiftClk gets edge detection; serialInput rides the same chain depth.
    io_shift_reg_sync_edge_det #(
        .STAGES (SYNC_STAGES),
        .DATA_W (1)
    ) u_sync (
        .clk        (masterClk),
        .rst        (rst),
        .async_clk  (bus.shiftClk),
        .async_data (bus.serialInput),
        .sync_data  (ser_in_sync),
        .rise       (shift_edge)
    );

    // A load in the same cycle as an edge takes priority and discards the edge.
    assign accept_shift = shift_edge & bus.enableShift & ~bus.load;

    // Register contents after one shift in the configured direction.
    always_comb begin
        if (ORDER == ORDER_MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], ser_in_sync};
        end else begin
            shifted = {ser_in_sync, shift_q[WIDTH-1:1]};
        end
    end

    // Next-state for register, counter, flags and shadow copy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        shift_d  = shift_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        coll_d   = coll_q;

        if (bus.load) begin
            shift_d  = bus.parallelInput;
            loaded_d = 1'b1;
            cnt_d    = '0;
            if (shift_edge) begin
                coll_d = 1'b1;
            end
        end else if (accept_shift) begin
            shift_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
                // Frame complete: wrap instead of reaching WIDTH.
                cnt_d    = '0;
                done_d   = 1'b1;
                loaded_d = 1'b0;
                if (OUT_LATCHED != 0) begin
                    shadow_d = shifted;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset; partial frames are dropped.
    always_ff @(posedge masterClk) begin
        if (rst) begin
            shift_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            coll_q   <= coll_d;
        end
    end

    assign bus.parallelOutput = (OUT_LATCHED != 0) ? shadow_q : shift_q;
    assign bus.serialOutput   = (ORDER == ORDER_MSB_FIRST) ? shift_q[WIDTH-1] : shift_q[0];
    assign bus.loaded         = loaded_q;
    assign bus.frameDone      = done_q;
    assign bus.bitCount       = cnt_q;
    assign bus.collision      = coll_q;

endmodule
